audio_run_ctrl: RTL
===================

Name: audio_run_ctrl

Overview:
- Sequencer between board controls, the audio processor datapath and the audio output stage.
- Holds the core in reset, latches the algorithm select at start, then releases the core.
- Buffers the samples the core writes to R6 in a small FIFO and replays them at a fixed sample-rate tick.
- Back-pressures the core when the buffer fills, and drains/finishes when the core raises its end flag (R14).

Parameters:
DATA_W, 11, sample width (matches R6 audio register).
FIFO_DEPTH, 8, sample buffer entries; power of two, at least 4.
TICK_DIV, 1042, clkFPGA cycles per output sample period; at least 2.
RST_CYCLES, 4, cycles core_rst is held after start; at least 1.

Ports:
clkFPGA  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  run request; level sampled each cycle.
alg_sel  in  1  algorithm select switch; latched on accepted start.
core_rst  out  1  reset to datapath, active-high.
core_en  out  1  datapath clock-enable/stall; 1 = core may advance.
core_alg  out  1  latched algorithm select, drives datapath R13 input.
core_done  in  1  datapath end flag (R14).
sample_we  in  1  datapath wrote a new R6 sample this cycle.
sample_in  in  DATA_W  R6 sample value.
audio_out  out  DATA_W  current output sample.
audio_valid  out  1  one-cycle pulse when audio_out updates.
busy  out  1  high in RESET_CORE, RUN, DRAIN.
done  out  1  high in DONE.
overflow  out  1  sticky: a sample was dropped.
underrun_cnt  out  8  saturating count of empty ticks in RUN.

Behaviour:
- Reset (rst=1 at a clock edge) takes effect on the next cycle, from any state, mid-run included:
  - state=IDLE, core_rst=1, core_en=0, core_alg=0, audio_out=0, audio_valid=0, busy=0, done=0, overflow=0, underrun_cnt=0.
  - FIFO empty, tick counter 0.
- All outputs are registered.
- States:
  - IDLE: core_rst=1, core_en=0. start=1 -> latch core_alg<=alg_sel, clear overflow and underrun_cnt, go to RESET_CORE.
  - RESET_CORE: core_rst=1, core_en=0 for exactly RST_CYCLES cycles, then RUN. core_done and sample_we are ignored here.
  - RUN: core_rst=0. core_en=1 iff FIFO count < FIFO_DEPTH-1; the one-entry margin absorbs an in-flight write. core_done=1 -> DRAIN on the next cycle. A sample_we in that same cycle is still accepted.
  - DRAIN: core_rst=0, core_en=0, sample_we ignored. Ticks keep popping; FIFO empty at a tick -> DONE.
  - DONE: done=1, busy=0, core_en=0, core_rst=0 (core state stays observable). start=1 -> relatch alg_sel, go to RESET_CORE.
  - start is ignored in RESET_CORE, RUN and DRAIN.
- Tick:
  - The counter runs only in RUN and DRAIN and is cleared to 0 on entering RUN.
  - Tick asserted when counter==TICK_DIV-1, then counter wraps to 0.
  - First tick occurs TICK_DIV cycles after RUN entry.
- On tick with FIFO non-empty: pop head; audio_out<=head; audio_valid=1 for that single cycle.
- On tick with FIFO empty:
  - In RUN: underrun_cnt increments, saturating at 255. audio_out holds, audio_valid=0.
  - In DRAIN: transition to DONE.
- Push: sample_we in RUN writes sample_in when count < FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs the same cycle.
- Push otherwise: sample dropped, overflow<=1 (sticky until next start or rst).
- Simultaneous push and pop: both happen, count unchanged, FIFO order preserved.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Latency: sample written in cycle N can appear on audio_out no earlier than the first tick after N+1.

Decomposition:
- Package audio_ctrl_pkg: state enum (IDLE, RESET_CORE, RUN, DRAIN, DONE), DATA_W default, underrun counter width constant.
- Sub-module sample_fifo (synchronous FIFO):
  - Parameters: DEPTH, W.
  - Ports: push, pop, din, dout, count, full, empty.
  - Write-while-full-with-pop allowed.
- Controller FSM, tick divider and status flags stay in audio_run_ctrl.

Test Plan (TICK_DIV=4, FIFO_DEPTH=4, RST_CYCLES=4):
- Start/config: rst 2 cycles, alg_sel=1, start 1 cycle -> core_alg=1, core_rst high exactly 4 cycles, then core_en=1, busy=1; toggling alg_sel later leaves core_alg=1.
- Streaming order: in RUN push 0x005, 0x3FF, 0x123 on consecutive cycles -> audio_out=0x005, 0x3FF, 0x123 at ticks 4 cycles apart, audio_valid one cycle each.
- Back-pressure/overflow: push every cycle with no tick -> core_en drops at count=3; 5th push with count=4 -> overflow=1, count stays 4; a push coinciding with a pop at count=4 is accepted.
- Underrun: no pushes for 3 ticks in RUN -> underrun_cnt=3, audio_out holds last value; 300 empty ticks -> saturates at 255.
- Finish: 2 samples buffered, core_done=1 -> DRAIN, core_en=0, both samples output, next empty tick -> done=1, busy=0; start again with alg_sel=0 -> core_alg=0, RESET_CORE.
- Mid-run reset: rst during RUN with 3 samples buffered -> next cycle IDLE, core_rst=1, audio_out=0, FIFO empty, underrun_cnt=0, overflow=0.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 11;  // width of the core's R6 audio register
  localparam int UNDERRUN_W = 8;   // saturating empty-tick counter width

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; dout is the current head.
// Latency: a pushed word is visible at dout one cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle;
  // the head is read combinationally before the write lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_run_ctrl.sv
// Sequences core reset/run, buffers R6 samples and replays them on a fixed tick.
// Latency: a sample written in cycle N reaches audio_out after the first tick past N+1.
// Backpressure: core_en drops while the buffer holds FIFO_DEPTH-1 or more samples.
module audio_run_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 1042,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clkFPGA,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  alg_sel,
  output logic                  core_rst,
  output logic                  core_en,
  output logic                  core_alg,
  input  logic                  core_done,
  input  logic                  sample_we,
  input  logic [DATA_W-1:0]     sample_in,
  output logic [DATA_W-1:0]     audio_out,
  output logic                  audio_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_t            state;
  state_t            state_nxt;
  logic [RC_W-1:0]   rst_cnt;
  logic [TK_W-1:0]   tick_cnt;
  logic              start_acc;
  logic              streaming;
  logic              tick;
  logic              pop;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     cnt_nxt;
  logic [DATA_W-1:0] fifo_dout;

  assign streaming = (state == RUN) || (state == DRAIN);
  assign tick      = streaming && (tick_cnt == TK_W'(TICK_DIV - 1));
  assign pop       = tick && !fifo_empty;
  // A write at full is still taken when the same-cycle pop frees the head slot.
  assign push      = (state == RUN) && sample_we && (!fifo_full || pop);
  assign drop      = (state == RUN) && sample_we && !push;
  assign cnt_nxt   = fifo_count + CW'(push) - CW'(pop);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clkFPGA),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state decode; start is only honoured from IDLE and DONE.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RESET_CORE;
        end
      end
      RESET_CORE: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN:        if (core_done) state_nxt = DRAIN;
      DRAIN:      if (tick && fifo_empty) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register plus the core-reset hold counter and sample-period divider.
  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state    <= IDLE;
      rst_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rst_cnt  <= (state == RESET_CORE) ? rst_cnt + RC_W'(1) : '0;
      // Divider idles at 0 outside RUN/DRAIN, so it starts from 0 on RUN entry.
      tick_cnt <= (!streaming || tick) ? '0 : tick_cnt + TK_W'(1);
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      core_rst     <= 1'b1;
      core_en      <= 1'b0;
      core_alg     <= 1'b0;
      audio_out    <= '0;
      audio_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      core_rst    <= (state_nxt == IDLE) || (state_nxt == RESET_CORE);
      // One-entry margin absorbs a write already in flight when core_en falls.
      core_en     <= (state_nxt == RUN) && (cnt_nxt < CW'(FIFO_DEPTH - 1));
      busy        <= (state_nxt == RESET_CORE) || (state_nxt == RUN) || (state_nxt == DRAIN);
      done        <= (state_nxt == DONE);
      audio_valid <= pop;
      if (pop) audio_out <= fifo_dout;
      if (start_acc) core_alg <= alg_sel;

      if (start_acc)  overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;

      if (start_acc) begin
        underrun_cnt <= '0;
      end else if ((state == RUN) && tick && fifo_empty && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
      end
    end
  end

endmodule
